// File: rtl/navre_io_pkg.sv
// Shared types and constants for the navre IO-mapped UART transmitter.
// Defines the TX state enum, default IO addresses and the status register layout.
package navre_io_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic [5:0] IO_DATA_ADDR_DFLT = 6'd42;
  localparam logic [5:0] IO_STAT_ADDR_DFLT = 6'd43;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  function automatic logic [7:0] status_byte(input logic busy, input logic full,
                                             input logic empty, input logic ovf);
    status_byte = 8'h00;
    status_byte[STAT_BUSY]  = busy;
    status_byte[STAT_FULL]  = full;
    status_byte[STAT_EMPTY] = empty;
    status_byte[STAT_OVF]   = ovf;
  endfunction

endpackage

// File: rtl/navre_io_fifo.sv
// Synchronous circular-buffer FIFO; read data is the head entry, combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module navre_io_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // count never exceeds DEPTH, so its top bit alone marks full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/navre_io_uart.sv
// IO-mapped UART TX: push at edge N starts the frame at N+1; full FIFO drops bytes (sticky overflow).
// Zero write to the data address raises eof once drained; NAVRE_UART_PARITY_EN adds an even-parity bit.
module navre_io_uart
  import navre_io_pkg::*;
#(
  parameter logic [5:0] IO_DATA_ADDR = IO_DATA_ADDR_DFLT,
  parameter logic [5:0] IO_STAT_ADDR = IO_STAT_ADDR_DFLT,
  parameter int         CLK_DIV      = 16,
  parameter int         FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [5:0] io_a,
  input  logic [7:0] io_do,
  output logic [7:0] io_di,
  output logic       txd,
  output logic       eof
);

  localparam logic [15:0]        DIV_M1     = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   FIFO_DEPTH = (FIFO_AW + 1)'(1 << FIFO_AW);

  tx_state_t         state, state_nx;
  logic [15:0]       cnt, cnt_nx;
  logic [2:0]        idx, idx_nx;
  logic [7:0]        shreg, shreg_nx;
  logic              par, par_nx;
  logic              txd_nx;
  logic              pop;
  logic              load;
  logic              bit_end;

  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;

  logic              wr_data, push_req, eof_req, stat_wr, stat_rd;
  logic              accept, drop;
  logic              ovf, eof_pending, eof_fire;

  assign wr_data  = io_we && (io_a == IO_DATA_ADDR);
  assign push_req = wr_data && (io_do != 8'h00);
  assign eof_req  = wr_data && (io_do == 8'h00);
  assign stat_wr  = io_we && (io_a == IO_STAT_ADDR);
  assign stat_rd  = io_re && (io_a == IO_STAT_ADDR);
  assign accept   = (fifo_count < FIFO_DEPTH) || pop;
  assign drop     = push_req && !accept;
  assign eof_fire = eof_pending && fifo_empty && (state == IDLE);

  navre_io_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req && accept),
    .pop   (pop),
    .wdata (io_do),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    par_nx   = par;
    txd_nx   = txd;
    pop      = 1'b0;
    load     = 1'b0;
    bit_end  = (cnt == 16'd0);

    case (state)
      IDLE: begin
        txd_nx = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_nx = DATA;
          cnt_nx   = DIV_M1;
          idx_nx   = 3'd0;
          txd_nx   = shreg[0];
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx = DIV_M1;
          if (idx == 3'd7) begin
`ifdef NAVRE_UART_PARITY_EN
            state_nx = PARITY;
            txd_nx   = par;
`else
            state_nx = STOP;
            txd_nx   = 1'b1;
`endif
          end else begin
            idx_nx   = idx + 3'd1;
            shreg_nx = shreg >> 1;
            txd_nx   = shreg[1];
          end
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          cnt_nx   = DIV_M1;
          txd_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // back-to-back frames: pop the next byte without an idle gap
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
            txd_nx   = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        txd_nx   = 1'b1;
      end
    endcase

    if (load) begin
      pop      = 1'b1;
      shreg_nx = fifo_rdata;
      par_nx   = ^fifo_rdata;
      cnt_nx   = DIV_M1;
      txd_nx   = 1'b0;
      state_nx = START;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      idx         <= 3'd0;
      shreg       <= 8'h00;
      par         <= 1'b0;
      txd         <= 1'b1;
      io_di       <= 8'h00;
      eof         <= 1'b0;
      eof_pending <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shreg       <= shreg_nx;
      par         <= par_nx;
      txd         <= txd_nx;
      eof         <= eof_fire;
      eof_pending <= eof_req || (eof_pending && !eof_fire);
      ovf         <= drop || (ovf && !stat_wr);
      io_di       <= stat_rd ? status_byte(state != IDLE, fifo_full, fifo_empty, ovf) : 8'h00;
    end
  end

endmodule

// File: tb/tb_navre_io_uart.sv
// Bench for navre_io_uart: directed sequences, a status vector table and randomized bursts.
module tb_navre_io_uart;

  localparam int CD = 4;
`ifdef NAVRE_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       io_re = 1'b0;
  logic       io_we = 1'b0;
  logic [5:0] io_a = 6'd0;
  logic [7:0] io_do = 8'h00;
  logic [7:0] io_di, di2;
  logic       txd, txd2, eof, eof2;

  navre_io_uart #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_do(io_do), .io_di(io_di), .txd(txd), .eof(eof)
  );

  navre_io_uart #(.CLK_DIV(CD), .FIFO_AW(2)) dut2 (
    .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a),
    .io_do(io_do), .io_di(di2), .txd(txd2), .eof(eof2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected on-wire frame, bit k = k-th bit time (start, 8 data LSB first, [parity], stop)
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    if (FB == 11) exp_frame = {1'b1, ^b, b, 1'b0};
    else          exp_frame = {2'b01, b, 1'b0};
  endfunction

  // Receiver: detects a start bit and samples mid-bit
  logic [10:0] rx_raw[$];
  int          rx_start[$];
  bit          rx_act = 1'b0;
  int          rx_cnt, rx_s;
  logic [10:0] rx_bits;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      rx_act = 1'b0;
    end else begin
      if (!rx_act && txd === 1'b0) begin
        rx_act = 1'b1; rx_cnt = 0; rx_s = cyc; rx_bits = '0;
      end
      if (rx_act) begin
        if (rx_cnt % CD == CD / 2) rx_bits[rx_cnt / CD] = txd;
        if (rx_cnt == (FB - 1) * CD + CD / 2) begin
          rx_raw.push_back(rx_bits);
          rx_start.push_back(rx_s);
          rx_act = 1'b0;
        end
        rx_cnt++;
      end
    end
  end

  int eof_cnt = 0;
  int eof_cyc = -1;
  always @(negedge clk) if (eof === 1'b1) begin eof_cnt++; eof_cyc = cyc; end

  task automatic wr(input logic [5:0] a, input logic [7:0] d, output int p);
    io_we = 1'b1; io_a = a; io_do = d; p = cyc + 1;
    @(posedge clk); @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] v);
    io_re = 1'b1; io_a = a;
    @(posedge clk); @(negedge clk);
    v = io_di; io_re = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_raw.delete(); rx_start.delete();
  endtask

  typedef struct {
    logic       we;
    logic       re;
    logic [5:0] a;
    logic [7:0] d;
    logic       chk;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, p, pz, s, e, n, g, eedge;
    int pq[$];
    logic [7:0] bq[$];
    logic [7:0] v, b;

    for (int i = 0; i < 6; i++) tbl[i] = '{1'b1, 1'b0, 6'd42, 8'h11 + 8'(i), 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 6'd43, 8'h00, 1'b1, 8'h0B};
    tbl[7]  = '{1'b1, 1'b0, 6'd43, 8'h5A, 1'b1, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 6'd43, 8'h00, 1'b1, 8'h03};
    tbl[9]  = '{1'b0, 1'b1, 6'd42, 8'h00, 1'b1, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 6'd5,  8'h00, 1'b1, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 6'd42, 8'h20, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 6'd43, 8'h00, 1'b1, 8'h0B};

    @(negedge clk);
    do_reset();
    chk("rst_txd", txd, 1); chk("rst_io_di", io_di, 0); chk("rst_eof", eof, 0);
    chk("rst_txd2", txd2, 1); chk("rst_eof2", eof2, 0);
    rd(6'd43, v); chk("rst_status", v, 8'h04);

    // Single byte 0x55: bit timing and busy
    clear_rx();
    wr(6'd42, 8'h55, t0);
    chk("s55_idle_at_push", txd, 1);
    for (int k = 0; k < FB; k++) begin
      logic [10:0] f;
      f = exp_frame(8'h55);
      wait_cyc(t0 + 1 + k * CD);
      chk($sformatf("s55_bit%0d", k), txd, f[k]);
    end
    wait_cyc(t0 + FL - 2);
    rd(6'd43, v); chk("s55_busy_stop", v, 8'h05);
    wait_cyc(t0 + 1 + FL);
    rd(6'd43, v); chk("s55_idle_after", v, 8'h04);

    // Three contiguous frames
    clear_rx();
    wr(6'd42, 8'h41, t0); wr(6'd42, 8'h42, p); wr(6'd42, 8'h43, p);
    wait_cyc(t0 + 20);
    rd(6'd43, v); chk("b2b_mid_status", v, 8'h01);
    wait_cyc(t0 + 1 + 3 * FL + 1);
    rd(6'd43, v); chk("b2b_end_status", v, 8'h04);
    chk("b2b_nframes", rx_raw.size(), 3);
    if (rx_raw.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b_frame%0d", i), rx_raw[i], exp_frame(8'h41 + 8'(i)));
        chk($sformatf("b2b_start%0d", i), rx_start[i], t0 + 1 + i * FL);
      end

    // 0x07: parity bit (when enabled) and frame length
    clear_rx();
    wr(6'd42, 8'h07, t0); wr(6'd42, 8'h01, p);
    wait_cyc(t0 + 1 + 2 * FL + 2);
    chk("p07_nframes", rx_raw.size(), 2);
    if (rx_raw.size() == 2) begin
      chk("p07_frame", rx_raw[0], exp_frame(8'h07));
      chk("p07_length", rx_start[1] - rx_start[0], FL);
    end

    // Overflow on the 4-deep instance, table driven
    do_reset();
    for (int i = 0; i < 13; i++) begin
      io_we = tbl[i].we; io_re = tbl[i].re; io_a = tbl[i].a; io_do = tbl[i].d;
      @(posedge clk); @(negedge clk);
      if (tbl[i].chk) chk($sformatf("tbl_row%0d", i), di2, tbl[i].exp);
    end
    io_we = 1'b0; io_re = 1'b0;

    // EOF marker after 0x31, zero written twice
    do_reset();
    clear_rx(); eof_cnt = 0;
    wr(6'd42, 8'h31, t0); wr(6'd42, 8'h00, p); wr(6'd42, 8'h00, p);
    for (int i = 0; i < FL + 50 && eof_cnt == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("eof_count", eof_cnt, 1);
    chk("eof_cycle", eof_cyc, t0 + 1 + FL + 1);
    chk("eof_nframes", rx_raw.size(), 1);
    if (rx_raw.size() == 1) chk("eof_frame", rx_raw[0], exp_frame(8'h31));

    // Reset in the middle of a frame
    clear_rx();
    wr(6'd42, 8'hA5, t0);
    wait_cyc(t0 + 8);
    rd(6'd43, v); chk("mid_busy", v, 8'h05);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", txd, 1); chk("mid_rst_di", io_di, 0); chk("mid_rst_eof", eof, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_txd", txd, 1);
    rd(6'd43, v); chk("mid_rel_status", v, 8'h04);
    clear_rx();
    wr(6'd42, 8'h7E, t1);
    wait_cyc(t1 + 1 + FL + 2);
    chk("mid_7e_nframes", rx_raw.size(), 1);
    if (rx_raw.size() == 1) begin
      chk("mid_7e_frame", rx_raw[0], exp_frame(8'h7E));
      chk("mid_7e_start", rx_start[0], t1 + 1);
    end

    // Randomized bursts against a timing model
    for (int r = 0; r < 4; r++) begin
      clear_rx(); eof_cnt = 0; pq.delete(); bq.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        g = $urandom_range(0, 50);
        repeat (g) @(negedge clk);
        b = 8'($urandom_range(1, 255));
        wr(6'd42, b, p);
        pq.push_back(p); bq.push_back(b);
      end
      g = $urandom_range(0, 60);
      repeat (g) @(negedge clk);
      wr(6'd42, 8'h00, pz);
      e = -1000000;
      for (int i = 0; i < n; i++) begin
        s = (pq[i] + 1 > e) ? pq[i] + 1 : e;
        pq[i] = s;
        e = s + FL;
      end
      eedge = ((pz > e) ? pz : e) + 1;
      for (int i = 0; i < 12 * FL && eof_cnt == 0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk($sformatf("rnd%0d_eof_count", r), eof_cnt, 1);
      chk($sformatf("rnd%0d_eof_cycle", r), eof_cyc, eedge);
      chk($sformatf("rnd%0d_nframes", r), rx_raw.size(), n);
      if (rx_raw.size() == n)
        for (int i = 0; i < n; i++) begin
          chk($sformatf("rnd%0d_frame%0d", r, i), rx_raw[i], exp_frame(bq[i]));
          chk($sformatf("rnd%0d_start%0d", r, i), rx_start[i], pq[i]);
        end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/navre_io_uart.md
Name: navre_io_uart

Overview:
- IO-mapped UART transmitter that sits downstream of the navre core's IO port. It consumes io_we/io_a/io_do writes to the console data address (42) and serialises the bytes on txd.
- A write of 0x00 is the end-of-output marker. The block asserts eof once all preceding bytes have left the wire, and the bench/top-level uses that to finish simulation.
- A small FIFO decouples the core's burst writes from the slow serial line. A status register lets firmware poll for flow control.

Parameters:
- IO_DATA_ADDR, 42, IO address of the TX data register (write-only).
- IO_STAT_ADDR, 43, IO address of the status register (read; write clears overflow).
- CLK_DIV, 16, clocks per serial bit; legal range 2..65535.
- FIFO_AW, 4, log2 of FIFO depth (default depth 16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- io_re  in  1  core IO read strobe.
- io_we  in  1  core IO write strobe.
- io_a  in  6  core IO address.
- io_do  in  8  core IO write data.
- io_di  out  8  IO read data to core, registered.
- txd  out  1  serial output, idle high.
- eof  out  1  one-cycle pulse when end-of-output has drained.

Behaviour:
- Reset (rst=0 at an edge): io_di=0, txd=1, eof=0, FIFO emptied, overflow=0, eof_pending=0, FSM=IDLE. Reset mid-frame aborts the frame immediately, and txd is high after that edge.
- Data write:
  - io_we && io_a==IO_DATA_ADDR && io_do!=0 pushes io_do.
  - The push is accepted if count<depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- EOF write: io_we && io_a==IO_DATA_ADDR && io_do==0 is not pushed; it sets eof_pending.
- eof drain: when eof_pending && FIFO empty && FSM==IDLE, eof=1 for exactly one cycle and eof_pending clears. Repeated zero writes before the drain yield a single pulse.
- Status write: io_we && io_a==IO_STAT_ADDR clears overflow. If overflow is set in the same cycle, the set wins.
- Status read: io_di at edge N+1 reflects io_re && io_a==IO_STAT_ADDR at edge N.
  - Bit0 = busy (FSM!=IDLE).
  - Bit1 = full.
  - Bit2 = empty.
  - Bit3 = overflow.
  - Bits 7:4 = 0.
  - Any other read gives io_di=0 at the next edge.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
  - Each bit state holds for CLK_DIV clocks using a down-counter.
  - IDLE with the FIFO non-empty pops at that edge and drives txd=0 (START).
  - DATA shifts 8 bits LSB first, with a 3-bit index.
  - STOP drives txd=1 for CLK_DIV clocks. At the end of STOP, if the FIFO is non-empty it pops and goes directly to START (no idle gap); otherwise it goes to IDLE.
- Latency: a push at edge N gives txd low after edge N+1 (when idle). A frame lasts 10*CLK_DIV clocks (11*CLK_DIV with parity).
- FIFO: circular buffer with FIFO_AW-bit pointers that wrap naturally. The count is FIFO_AW+1 bits wide. Simultaneous push and pop on a full FIFO keeps count=depth.
- IO activity to any other address is ignored.

Optional Feature:
- Macro NAVRE_UART_PARITY_EN.
- Defined: a PARITY state follows DATA and drives even parity (XOR of the 8 data bits) for CLK_DIV clocks. The frame is 11 bits.
- Undefined: no PARITY state, 10-bit frame (8N1). Status layout is unchanged either way.

Decomposition:
- Package navre_io_pkg:
  - TX state enum (IDLE, START, DATA, PARITY, STOP).
  - Default IO address constants 42/43.
  - Status bit index constants (STAT_BUSY=0, STAT_FULL=1, STAT_EMPTY=2, STAT_OVF=3).
- Sub-module navre_io_fifo: parameterised synchronous FIFO with push/pop/full/empty/count. The top holds the address decode, status, eof logic and TX FSM.

Test Plan:
- CLK_DIV=4, write 0x55 -> txd low after the next edge; sampled every 4 clocks txd = 0,1,0,1,0,1,0,1,0,1; then high; busy reads 1 during the frame and 0 after 40 clocks.
- Write 0x41, 0x42, 0x43 back-to-back -> three contiguous frames with no idle gap (120 clocks at CLK_DIV=4); status read mid-stream shows empty=0, and empty=1 at the end.
- FIFO_AW=2, write 6 bytes in consecutive cycles while idle -> first byte popped, 4 buffered, 1 dropped; status=0x0B (busy|full|ovf); a write to 43 clears it to 0x03.
- Write 0x31 then 0x00 -> eof pulses exactly once, one cycle after the 0x31 stop bit ends; no frame is emitted for 0x00.
- Reset asserted (rst=0) at clock 10 of a frame -> txd=1, io_di=0 and status=0x04 after release; next write 0x7E transmits cleanly.
- With NAVRE_UART_PARITY_EN, write 0x07 -> parity bit 1, frame 11*CLK_DIV clocks; without it, 10*CLK_DIV.
